// File: rtl/sync_down_counter_nbit.sv
// -----------------------------------------------------------------------------
// sync_down_counter_nbit
//
// Loadable synchronous down counter, WIDTH bits wide. The count register is
// built from per-bit toggle flops: each bit flips when its toggle input is set.
// A load arms the counter (RUN) with a start value, and every enabled cycle
// decrements it. The step from 1 to 0 is the terminal count. It raises a
// registered one-cycle tc pulse. In one-shot mode (RELOAD=0) the counter then
// parks at 0 in IDLE. In auto-reload mode (RELOAD=1) it restarts from the last
// loaded value, which gives a periodic tick.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   RELOAD    0 = one-shot, 1 = auto-reload at terminal count
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state at once
//   en        in   1      count enable; one decrement per cycle while running
//   load      in   1      synchronous load strobe; has priority over en
//   load_val  in   WIDTH  start value captured when load=1
//   Q         out  WIDTH  current count
//   busy      out  1      1 while the counter is running
//   zero      out  1      combinational (Q == 0)
//   tc        out  1      registered one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module sync_down_counter_nbit #(
  parameter int WIDTH  = 4,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] dec_mask_s;   // bits that flip on a decrement
  logic [WIDTH-1:0] t_s;          // per-bit toggle enables

  // Decrement toggle mask: bit 0 always flips, and bit i flips only when all
  // lower bits are zero. These are the borrow positions of Q-1.
  always_comb begin
    dec_mask_s    = ALL_ZERO;
    dec_mask_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      dec_mask_s[i] = dec_mask_s[i-1] & ~q_q[i-1];
    end
  end

  // Next-state, next-count, reload capture and terminal-count decision
  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    if (load) begin
      // A load overrides everything, including a terminal decrement in the same cycle.
      q_d      = load_val;
      reload_d = load_val;
      state_d  = (load_val != ALL_ZERO) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (q_q == ONE) begin
              tc_d = 1'b1;
              if (RELOAD) begin
                q_d     = reload_q;
                state_d = RUN;
              end else begin
                q_d     = ALL_ZERO;
                state_d = IDLE;
              end
            end else begin
              q_d = q_q ^ dec_mask_s;
            end
          end else begin
            q_d = q_q;
          end
        end
        IDLE: begin
          // IDLE holds Q, so the counter can never wrap from 0 to all-ones.
          q_d = q_q;
        end
        default: begin
          q_d     = ALL_ZERO;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Each count bit is a toggle flop. It flips when the next value differs from the current one.
  assign t_s = q_q ^ q_d;

  // Toggle-flop count register, reload register, state and tc pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= ALL_ZERO;
      reload_q <= ALL_ZERO;
      state_q  <= IDLE;
      tc_q     <= 1'b0;
    end else begin
      q_q      <= q_q ^ t_s;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  assign Q    = q_q;
  assign busy = (state_q == RUN);
  assign zero = (q_q == ALL_ZERO);
  assign tc   = tc_q;

endmodule

// File: tb/tb_sync_down_counter_nbit.sv
// -----------------------------------------------------------------------------
// Bench for sync_down_counter_nbit. Two instances share all inputs: u0 runs in
// one-shot mode and u1 runs in auto-reload mode. For every directed step, a
// behavioural model pushes the expected outputs of both instances to a
// scoreboard queue. After the clock edge the entries are popped and compared.
// -----------------------------------------------------------------------------
module tb_sync_down_counter_nbit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q0, q1;
  logic       busy0, busy1, zero0, zero1, tc0, tc1;

  always #5 clk = ~clk;

  sync_down_counter_nbit #(.WIDTH(4), .RELOAD(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .Q(q0), .busy(busy0), .zero(zero0), .tc(tc0)
  );

  sync_down_counter_nbit #(.WIDTH(4), .RELOAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .Q(q1), .busy(busy1), .zero(zero1), .tc(tc1)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       zero;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural reference state, index 0 = one-shot, 1 = auto-reload
  logic [3:0] mq   [2];
  logic [3:0] mrel [2];
  logic       mrun [2];
  logic       mtc  [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 4'd0; mrel[k] = 4'd0; mrun[k] = 1'b0; mtc[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic e, input logic l,
                            input logic [3:0] v, input bit rl);
    mtc[k] = 1'b0;
    if (l) begin
      mq[k] = v; mrel[k] = v; mrun[k] = (v != 4'd0);
    end else if (mrun[k] && e) begin
      if (mq[k] > 4'd1) begin
        mq[k] = mq[k] - 4'd1;
      end else begin
        mtc[k] = 1'b1;
        if (rl) mq[k] = mrel[k];
        else begin mq[k] = 4'd0; mrun[k] = 1'b0; end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.q = mq[k]; e.busy = mrun[k]; e.zero = (mq[k] == 4'd0); e.tc = mtc[k];
      sb.push_back(e);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    chk({tag, "/sb"}, 8'(sb.size()), 8'd2);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk({tag, "/u0.Q"},    {4'd0, q0},    {4'd0, e.q});
      chk({tag, "/u0.busy"}, {7'd0, busy0}, {7'd0, e.busy});
      chk({tag, "/u0.zero"}, {7'd0, zero0}, {7'd0, e.zero});
      chk({tag, "/u0.tc"},   {7'd0, tc0},   {7'd0, e.tc});
      e = sb.pop_front();
      chk({tag, "/u1.Q"},    {4'd0, q1},    {4'd0, e.q});
      chk({tag, "/u1.busy"}, {7'd0, busy1}, {7'd0, e.busy});
      chk({tag, "/u1.zero"}, {7'd0, zero1}, {7'd0, e.zero});
      chk({tag, "/u1.tc"},   {7'd0, tc1},   {7'd0, e.tc});
    end
  endtask

  // Drive at the falling edge, predict, then compare 1 time unit after the rising edge.
  task automatic step(input string tag, input logic e, input logic l, input logic [3:0] v);
    en = e; load = l; load_val = v;
    model_step(0, e, l, v, 1'b0);
    model_step(1, e, l, v, 1'b1);
    push_exp();
    @(posedge clk);
    #1;
    compare(tag);
    @(negedge clk);
  endtask

  int pulses;
  logic [4:0] en_pat;

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0;
    #2;
    model_reset();
    push_exp();
    compare("rst_init");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-count: load 9, three decrements to 6, then async reset between edges
    step("mid_load", 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) step($sformatf("mid_en%0d", i), 1'b1, 1'b0, 4'd0);
    chk("mid_q_before", {4'd0, q0}, 8'd6);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp();
    compare("rst_mid");
    #1;
    reset = 1'b0;
    @(negedge clk);

    // One-shot: load 5 with en held high, then extra enables at 0
    step("os_load", 1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 7; i++) step($sformatf("os_en%0d", i), 1'b1, 1'b0, 4'd0);

    // Enable gating: load 3, en pattern 1,0,0,1,1
    step("gate_load", 1'b0, 1'b1, 4'd3);
    en_pat = 5'b11001;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("gate%0d", i), en_pat[i], 1'b0, 4'd0);
      pulses += int'(tc0);
    end
    chk("gate_tc_count", 8'(pulses), 8'd1);

    // Auto-reload: load 3, nine enabled cycles
    step("ar_load", 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 9; i++) step($sformatf("ar_en%0d", i), 1'b1, 1'b0, 4'd0);

    // Load collision at Q=1: the load wins and no tc is raised
    step("col_load2", 1'b0, 1'b1, 4'd2);
    step("col_dec", 1'b1, 1'b0, 4'd0);
    step("col_hit", 1'b1, 1'b1, 4'd7);

    // Edge value 0: the counter idles without tc
    step("zero_load", 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 2; i++) step($sformatf("zero_en%0d", i), 1'b1, 1'b0, 4'd0);

    // Auto-reload with reload value 1: tc on every enabled cycle
    step("r1_load", 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) step($sformatf("r1_en%0d", i), 1'b1, 1'b0, 4'd0);

    // Full range: load 15, count down to 0 with exactly one one-shot tc
    step("full_load", 1'b0, 1'b1, 4'd15);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step($sformatf("full_en%0d", i), 1'b1, 1'b0, 4'd0);
      pulses += int'(tc0);
    end
    chk("full_tc_count", 8'(pulses), 8'd1);
    chk("full_q_end", {4'd0, q0}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
